// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Holds the controller state encoding, the register-zero constant, the
// default timeout/counter widths and the bundled pipeline control word
// together with the canonical control patterns.
package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO    = 5'd0;
   localparam int         DEF_TIMEOUT = 255;
   localparam int         DEF_CNT_W   = 16;

   // Five register load enables followed by the three squash controls.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_bubble;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_RUN      = 8'b11111_000;
   localparam pipe_ctrl_t CTRL_FREEZE   = 8'b00001_001;
   localparam pipe_ctrl_t CTRL_LOAD_USE = 8'b00111_010;
   localparam pipe_ctrl_t CTRL_BRANCH   = 8'b11111_110;
   localparam pipe_ctrl_t CTRL_RESET    = 8'b11111_111;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare.
// Flags when the load in EX writes a register (other than $zero) that the
// instruction in ID reads through rs or rt.
//   ex_memread, ex_rt : load in EX and its destination
//   id_rs, id_rt      : source fields of the instruction in ID
//   hazard            : dependent instruction must wait one cycle
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   output logic       hazard
);

   assign hazard = ex_memread && (ex_rt != REG_ZERO) &&
                   ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage pipeline.
// Produces the PC / pipeline register load enables and squash controls from
// load-use hazards, taken branches and a req/ack data-memory handshake, and
// keeps a saturating count of frozen or stalled cycles.
//   clk, rst                      : clock, synchronous active-high reset
//   id_rs, id_rt, ex_memread,
//   ex_rt, ex_branch_taken        : hazard/branch information from ID and EX
//   mem_access, dmem_ack          : MEM-stage access and memory completion
//   dmem_req                      : data-memory request
//   *_en, *_flush, memwb_bubble   : pipeline register controls
//   timeout_err                   : sticky memory-timeout flag
//   stall_count                   : saturating frozen/stalled cycle count
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ack,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_bubble,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_count
);

   localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

   state_t             state_r;
   state_t             state_nxt_s;
   logic [WAIT_W-1:0]  wait_cnt_r;
   logic [WAIT_W-1:0]  wait_cnt_nxt_s;
   logic               timeout_err_r;
   logic [CNT_W-1:0]   stall_count_r;

   logic               hazard_s;
   pipe_ctrl_t         run_ctrl_s;
   logic               run_stall_s;
   pipe_ctrl_t         ctrl_s;
   logic               stall_s;
   logic               req_s;
   logic               timeout_hit_s;

   load_use_detect u_load_use_detect (
      .ex_memread (ex_memread),
      .ex_rt      (ex_rt),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .hazard     (hazard_s)
   );

   // Control word when the pipeline is free to move: branch beats load-use,
   // since the flush discards the dependent instruction anyway.
   always_comb begin
      run_ctrl_s  = CTRL_RUN;
      run_stall_s = 1'b0;
      if (ex_branch_taken) begin
         run_ctrl_s  = CTRL_BRANCH;
         run_stall_s = 1'b0;
      end else if (hazard_s) begin
         run_ctrl_s  = CTRL_LOAD_USE;
         run_stall_s = 1'b1;
      end else begin
         run_ctrl_s  = CTRL_RUN;
         run_stall_s = 1'b0;
      end
   end

   // Handshake FSM: next state, wait counter and final control word.
   // The release cycle (ack or timeout) re-evaluates branch/hazard inputs.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      ctrl_s         = run_ctrl_s;
      stall_s        = run_stall_s;
      req_s          = 1'b0;
      timeout_hit_s  = 1'b0;
      if (rst) begin
         state_nxt_s    = ST_RUN;
         wait_cnt_nxt_s = WAIT_ZERO;
         ctrl_s         = CTRL_RESET;
         stall_s        = 1'b0;
         req_s          = 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (mem_access && !dmem_ack) begin
                  req_s          = 1'b1;
                  ctrl_s         = CTRL_FREEZE;
                  stall_s        = 1'b1;
                  state_nxt_s    = ST_MEM_WAIT;
                  wait_cnt_nxt_s = WAIT_ONE;
               end else begin
                  // Zero-wait access or no access: pipeline advances.
                  req_s          = mem_access;
                  wait_cnt_nxt_s = WAIT_ZERO;
               end
            end
            ST_MEM_WAIT: begin
               if (dmem_ack) begin
                  req_s          = 1'b1;
                  state_nxt_s    = ST_RUN;
                  wait_cnt_nxt_s = WAIT_ZERO;
               end else if (wait_cnt_r >= TIMEOUT_V) begin
                  // Abandon the access and release as if it had completed.
                  req_s          = 1'b0;
                  timeout_hit_s  = 1'b1;
                  state_nxt_s    = ST_RUN;
                  wait_cnt_nxt_s = WAIT_ZERO;
               end else begin
                  req_s          = 1'b1;
                  ctrl_s         = CTRL_FREEZE;
                  stall_s        = 1'b1;
                  wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
               end
            end
            default: begin
               state_nxt_s    = ST_RUN;
               wait_cnt_nxt_s = WAIT_ZERO;
               ctrl_s         = CTRL_FREEZE;
               stall_s        = 1'b0;
               req_s          = 1'b0;
            end
         endcase
      end
   end

   // State, wait counter, sticky timeout flag and saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_RUN;
         wait_cnt_r    <= WAIT_ZERO;
         timeout_err_r <= 1'b0;
         stall_count_r <= CNT_ZERO;
      end else begin
         state_r       <= state_nxt_s;
         wait_cnt_r    <= wait_cnt_nxt_s;
         timeout_err_r <= timeout_err_r | timeout_hit_s;
         if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + CNT_ONE;
         end else begin
            stall_count_r <= stall_count_r;
         end
      end
   end

   assign dmem_req     = req_s;
   assign pc_en        = ctrl_s.pc_en;
   assign ifid_en      = ctrl_s.ifid_en;
   assign idex_en      = ctrl_s.idex_en;
   assign exmem_en     = ctrl_s.exmem_en;
   assign memwb_en     = ctrl_s.memwb_en;
   assign ifid_flush   = ctrl_s.ifid_flush;
   assign idex_flush   = ctrl_s.idex_flush;
   assign memwb_bubble = ctrl_s.memwb_bubble;
   // Visible on the cycle the timeout is detected, then held by the flop.
   assign timeout_err  = timeout_err_r | timeout_hit_s;
   assign stall_count  = stall_count_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: a directed vector table, a
// saturation sequence and randomized stimulus checked against a cycle-level
// behavioural model of the stall/flush rules.
module tb_pipe_stall_ctrl;

   localparam int TO  = 4;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   localparam logic [7:0] C_RUN = 8'b11111_000;
   localparam logic [7:0] C_FRZ = 8'b00001_001;
   localparam logic [7:0] C_LU  = 8'b00111_010;
   localparam logic [7:0] C_BR  = 8'b11111_110;
   localparam logic [7:0] C_RST = 8'b11111_111;

   typedef struct packed {
      logic       rst;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       mr;
      logic [4:0] ert;
      logic       br;
      logic       mem;
      logic       ack;
      logic [7:0] ctrl;
      logic       req;
      logic       err;
      logic [3:0] cnt;
   } row_t;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic ex_memread, ex_branch_taken, mem_access, dmem_ack;
   logic dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic ifid_flush, idex_flush, memwb_bubble, timeout_err;
   logic [CW-1:0] stall_count;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
      .mem_access(mem_access), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .memwb_bubble(memwb_bubble), .timeout_err(timeout_err), .stall_count(stall_count)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model: cycles spent waiting on memory, error flag, stall total.
   int   m_wait   = 0;
   bit   m_err    = 1'b0;
   int   m_stalls = 0;
   int   nx_wait;
   bit   nx_err;
   bit   m_stall_now;
   logic [7:0] e_ctrl;
   bit   e_req, e_err;
   int   e_cnt;

   row_t tbl[$];

   function automatic row_t mk(input logic r, input int rs, input int rt, input logic mr,
                               input int ert, input logic br, input logic mem, input logic ack,
                               input logic [7:0] ctrl, input logic req, input logic err,
                               input int cnt);
      row_t x;
      x.rst = r; x.rs = 5'(rs); x.rt = 5'(rt); x.mr = mr; x.ert = 5'(ert);
      x.br = br; x.mem = mem; x.ack = ack; x.ctrl = ctrl; x.req = req;
      x.err = err; x.cnt = 4'(cnt);
      return x;
   endfunction

   task automatic cmp(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
      end
   endtask

   // Expected outputs for the current inputs, from the controller's rules.
   task automatic model_eval();
      bit hz, freeze, to_now;
      hz = ex_memread && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
      freeze = 1'b0; to_now = 1'b0; nx_wait = 0;
      if (rst) begin
         e_ctrl = C_RST; e_req = 1'b0; e_err = m_err; nx_err = 1'b0; m_stall_now = 1'b0;
      end else begin
         if (m_wait == 0) begin
            if (mem_access && !dmem_ack) begin freeze = 1'b1; nx_wait = 1; end
            e_req = mem_access;
         end else if (dmem_ack) begin
            e_req = 1'b1;
         end else if (m_wait >= TO) begin
            e_req = 1'b0; to_now = 1'b1;
         end else begin
            freeze = 1'b1; e_req = 1'b1; nx_wait = m_wait + 1;
         end
         if (freeze)               e_ctrl = C_FRZ;
         else if (ex_branch_taken) e_ctrl = C_BR;
         else if (hz)              e_ctrl = C_LU;
         else                      e_ctrl = C_RUN;
         m_stall_now = freeze || (!ex_branch_taken && hz);
         e_err  = m_err || to_now;
         nx_err = e_err;
      end
      e_cnt = m_stalls;
   endtask

   task automatic model_commit();
      m_wait = nx_wait;
      m_err  = nx_err;
      if (rst) m_stalls = 0;
      else if (m_stall_now && m_stalls < SAT) m_stalls = m_stalls + 1;
   endtask

   // One clock: drive inputs, sample at the falling edge, compare, advance.
   task automatic cycle(input bit use_tbl, input row_t r, input int idx);
      logic [7:0] act_ctrl;
      rst = r.rst; id_rs = r.rs; id_rt = r.rt; ex_memread = r.mr; ex_rt = r.ert;
      ex_branch_taken = r.br; mem_access = r.mem; dmem_ack = r.ack;
      @(negedge clk);
      model_eval();
      act_ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, memwb_bubble};
      if (use_tbl) begin
         cmp("tbl_ctrl", idx, 32'(act_ctrl), 32'(r.ctrl));
         cmp("tbl_req",  idx, 32'(dmem_req), 32'(r.req));
         cmp("tbl_err",  idx, 32'(timeout_err), 32'(r.err));
         cmp("tbl_cnt",  idx, 32'(stall_count), 32'(r.cnt));
      end else begin
         cmp("mdl_ctrl", idx, 32'(act_ctrl), 32'(e_ctrl));
         cmp("mdl_req",  idx, 32'(dmem_req), 32'(e_req));
         cmp("mdl_err",  idx, 32'(timeout_err), 32'(e_err));
         cmp("mdl_cnt",  idx, 32'(stall_count), 32'(e_cnt));
      end
      @(posedge clk);
      #1;
      model_commit();
   endtask

   initial begin
      row_t r;
      // rst rs rt mr ert br mem ack | ctrl req err cnt
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0));  // reset
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0));  // idle
      tbl.push_back(mk(0, 8, 0, 1, 8, 0, 0, 0, C_LU,  0, 0, 0));  // load-use on rs
      tbl.push_back(mk(0, 8, 0, 0, 8, 0, 0, 0, C_RUN, 0, 0, 1));  // hazard cleared
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, C_RUN, 0, 0, 1));  // $zero never stalls
      tbl.push_back(mk(0, 0, 5, 1, 5, 1, 0, 0, C_BR,  0, 0, 1));  // branch beats load-use
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 1));  // reset
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 0));  // first request
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 2));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 1, 0, 3));  // ack 3 cycles later
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 3));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 1, 0, 3));  // zero-wait
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 1, 0, 3));  // back-to-back zero-wait
      tbl.push_back(mk(0, 3, 0, 1, 3, 1, 1, 0, C_FRZ, 1, 0, 3));  // freeze ignores br/hazard
      tbl.push_back(mk(0, 3, 0, 1, 3, 0, 1, 1, C_LU,  1, 0, 4));  // release re-evaluates
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 5));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 5));  // timeout sequence
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 6));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 7));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 8));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_RUN, 0, 1, 9));  // 4th wait cycle: timeout
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 1, 9));  // sticky
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 1, 9));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 1, 10)); // in MEM_WAIT
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, C_RST, 0, 1, 11)); // reset drops req at once
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0));  // cleared
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1, 0, 0));  // fresh handshake from RUN
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 1, 0, 1));

      rst = 1'b1; id_rs = 5'd0; id_rt = 5'd0; ex_memread = 1'b0; ex_rt = 5'd0;
      ex_branch_taken = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) cycle(1'b1, tbl[i], i);

      // Continuous load-use stalls drive the 4-bit counter into saturation.
      r = mk(0, 9, 0, 1, 9, 0, 0, 0, C_RUN, 0, 0, 0);
      for (int i = 0; i < 20; i++) cycle(1'b0, r, 1000 + i);
      r = mk(0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0);
      rst = 1'b0; ex_memread = 1'b0; mem_access = 1'b0;
      @(negedge clk);
      cmp("saturate", 0, 32'(stall_count), 32'(SAT));
      @(posedge clk);
      #1;
      cycle(1'b0, r, 1100);

      // Randomized stimulus against the model; small register range for matches.
      for (int i = 0; i < 3000; i++) begin
         r.rst = ($urandom_range(0, 99) == 0);
         r.rs  = 5'($urandom_range(0, 3));
         r.rt  = 5'($urandom_range(0, 3));
         r.ert = 5'($urandom_range(0, 3));
         r.mr  = ($urandom_range(0, 1) == 1);
         r.br  = ($urandom_range(0, 5) == 0);
         r.mem = ($urandom_range(0, 2) == 0);
         r.ack = ($urandom_range(0, 2) == 0);
         cycle(1'b0, r, 2000 + i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
